// File: rtl/ysyx_25050147_lsu_store_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_25050147_lsu_store_pkg
// Shared definitions for the LSU store path:
//   - store op encodings (sb / sh / sw)
//   - AXI write response code OKAY
//   - store FSM state enum
//   - base byte mask per op, before lane shifting
// Optional macro used by the store path: YSYX_25050147_STORE_ALIGN_CHECK_EN
// -----------------------------------------------------------------------------
package ysyx_25050147_lsu_store_pkg;

    localparam logic [2:0] OP_SB = 3'b000;
    localparam logic [2:0] OP_SH = 3'b001;
    localparam logic [2:0] OP_SW = 3'b010;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT_B = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Byte mask for an access at offset 0. Illegal ops give an empty mask,
    // which the lane logic uses as its illegal-op indication.
    function automatic logic [3:0] base_mask(input logic [2:0] op);
        logic [3:0] m;
        case (op)
            OP_SB:   m = 4'b0001;
            OP_SH:   m = 4'b0011;
            OP_SW:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_25050147_lsu_store_lane.sv
// -----------------------------------------------------------------------------
// ysyx_25050147_store_lane
// Combinational lane steering for a store:
//   op    [2:0]  store op (sb/sh/sw; anything else is illegal)
//   off   [1:0]  byte offset = address[1:0]
//   data  [31:0] LSB-aligned store data
//   wdata [31:0] data shifted to its byte lane (upper bytes truncated)
//   wstrb [3:0]  base mask shifted by offset (truncated to 4 bits)
//   illegal      op is not sb/sh/sw
//   misalign     sh at odd offset / sw at non-zero offset; only produced when
//                YSYX_25050147_STORE_ALIGN_CHECK_EN is defined, otherwise 0
// -----------------------------------------------------------------------------
module ysyx_25050147_store_lane
    import ysyx_25050147_lsu_store_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        illegal,
    output logic        misalign
);

    logic [3:0] mask;

    always_comb begin
        mask    = base_mask(op);
        illegal = (mask == 4'b0000);
        // Shifting past bit 31 / bit 3 simply drops bytes: a misaligned
        // store without the alignment check writes only the lanes that fit.
        wdata   = data << {off, 3'b000};
        wstrb   = mask << off;
    end

`ifdef YSYX_25050147_STORE_ALIGN_CHECK_EN
    always_comb begin
        case (op)
            OP_SH:   misalign = off[0];
            OP_SW:   misalign = (off != 2'b00);
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/ysyx_25050147_lsu_store.sv
// -----------------------------------------------------------------------------
// ysyx_25050147_lsu_store
// Store side of the LSU. Takes one sb/sh/sw request, steers data into byte
// lanes, issues a single AXI4-Lite write (AW + W, then B) and returns a
// one-cycle completion pulse with an error flag. One store in flight.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op/req_addr/req_data   store op, byte address, LSB-aligned data
//   resp_valid/resp_err        one-cycle completion pulse, error qualifier
//   awvalid/awready/awaddr     AXI write address (word aligned)
//   wvalid/wready/wdata/wstrb  AXI write data and byte strobes
//   bvalid/bready/bresp        AXI write response
//   dbg_state                  current FSM state (state_t encoding)
//
// Handshake rule for every channel here: a transfer happens on a rising
// clock edge where valid and ready are both high; a valid, once raised, is
// held with its payload stable until that transfer, and valid never depends
// combinationally on ready.
//
// Optional macro: YSYX_25050147_STORE_ALIGN_CHECK_EN rejects misaligned
// sh/sw with an error response and no bus activity.
// -----------------------------------------------------------------------------
module ysyx_25050147_lsu_store
    import ysyx_25050147_lsu_store_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,

    output logic        resp_valid,
    output logic        resp_err,

    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,

    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,

    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,

    output logic [1:0]  dbg_state
);

    state_t      state;
    state_t      next_state;

    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic        lane_illegal;
    logic        lane_misalign;
    logic        lane_fault;

    logic        accept;
    logic        aw_clear;
    logic        w_clear;
    logic        err_q;

    ysyx_25050147_store_lane u_lane (
        .op       (req_op),
        .off      (req_addr[1:0]),
        .data     (req_data),
        .wdata    (lane_wdata),
        .wstrb    (lane_wstrb),
        .illegal  (lane_illegal),
        .misalign (lane_misalign)
    );

    assign lane_fault = lane_illegal | lane_misalign;
    assign accept     = req_valid & req_ready & (state == ST_IDLE);

    // A channel counts as finished when its valid is already down or it is
    // handshaking this cycle; this lets AW and W finish in either order.
    assign aw_clear = ~awvalid | awready;
    assign w_clear  = ~wvalid  | wready;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = lane_fault ? ST_RESP : ST_SEND;
                end
            end
            ST_SEND: begin
                if (aw_clear && w_clear) begin
                    next_state = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (bvalid) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------ state-decoded outputs
    always_comb begin
        bready     = (state == ST_WAIT_B);
        resp_valid = (state == ST_RESP);
        resp_err   = (state == ST_RESP) & err_q;
        dbg_state  = state;
    end

    // ------------------------------------------------- registered datapath
    // req_ready is a flop so it stays low while reset is asserted and
    // rises the cycle after reset is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            awaddr    <= 32'h0;
            wdata     <= 32'h0;
            wstrb     <= 4'h0;
            err_q     <= 1'b0;
        end else begin
            req_ready <= (next_state == ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        awaddr  <= {req_addr[31:2], 2'b00};
                        wdata   <= lane_wdata;
                        wstrb   <= lane_wstrb;
                        err_q   <= lane_fault;
                        awvalid <= ~lane_fault;
                        wvalid  <= ~lane_fault;
                    end
                end
                ST_SEND: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                end
                ST_WAIT_B: begin
                    if (bvalid) begin
                        err_q <= (bresp != RESP_OKAY);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/ysyx_25050147_lsu_store.md
# ysyx_25050147_lsu_store

Store-side counterpart of the load-data extractor in the LSU. Accepts one store request from the EXU/LSU pipeline (sb/sh/sw), lane-shifts the data and builds byte strobes, then issues a single AXI4-Lite write transaction (AW, W, B) and returns a one-cycle completion/error pulse to the pipeline. One outstanding store at a time.

## Interface
- Parameters: none.
- `clk` input 1: single clock.
- `rst_n` input 1: synchronous, active-low reset.
- `req_valid` input 1: store request valid.
- `req_ready` output 1: high only in IDLE; request accepted on `req_valid & req_ready`.
- `req_op` input 3: 000 sb, 001 sh, 010 sw; any other value is illegal.
- `req_addr` input 32: byte address.
- `req_data` input 32: store data, LSB-aligned.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_err` output 1: qualified by `resp_valid`; 1 on illegal op, misalignment or bus error.
- `awvalid`/`awready` output/input 1: AW handshake.
- `awaddr` output 32: `req_addr` with bits [1:0] cleared.
- `wvalid`/`wready` output/input 1: W handshake.
- `wdata` output 32: lane-shifted store data.
- `wstrb` output 4: byte strobes.
- `bvalid` input 1, `bready` output 1, `bresp` input 2: write response.

## Operation
- States: IDLE, SEND, WAIT_B, RESP.
- IDLE: `req_ready`=1. On accept, latch `awaddr`, `wdata`, `wstrb`, op; go to SEND (or RESP with error, see below).
- Lane rules, off = `req_addr[1:0]`: `wdata` = `req_data << (8*off)` (truncated to 32); base mask sb 0001, sh 0011, sw 1111; `wstrb` = (base << off) truncated to 4 bits.
- Illegal op: no bus activity; go to RESP with `resp_err`=1.
- SEND: `awvalid` and `wvalid` both rise the cycle after acceptance. Each drops independently in the cycle after its own handshake; never re-raised. AW and W may complete in either order or the same cycle. When both done, go to WAIT_B. `awaddr`/`wdata`/`wstrb` stable while respective valid high.
- WAIT_B: `bready`=1. On `bvalid`, latch err = (`bresp` != 00); go to RESP. `bvalid` arriving in SEND is ignored (`bready`=0 there).
- RESP: `resp_valid`=1 for exactly one cycle, `req_ready`=0; then IDLE.
- Reset: state IDLE; all outputs 0 (`req_ready` becomes 1 in the first cycle after reset deasserts). Reset mid-transaction abandons it; valids drop in the cycle after reset is sampled; no response generated.

## Timing
- Best-case: accept cycle T; AW/W handshake T+1; `bvalid` T+2; `resp_valid` T+3; next accept T+4.
- Stalls on `awready`, `wready`, `bvalid` extend SEND/WAIT_B without bound; no timeout.
- Error (illegal op/misaligned): `resp_valid` at T+1, no AW/W.
- All outputs registered or decoded from state only; no combinational path from AXI inputs to AXI outputs.

## Configuration
- `YSYX_25050147_STORE_ALIGN_CHECK_EN` defined: sh with `req_addr[0]`=1, or sw with `req_addr[1:0]`!=00, is misaligned: no bus activity, RESP with `resp_err`=1 at T+1.
- Not defined: no check; misaligned stores issue with truncated strobes per lane rule (e.g. sh at off 3 -> `wstrb` 1000, upper byte dropped), `resp_err` from `bresp` only.

## Structure
- Shared package: store op encodings (SB/SH/SW), state enum, AXI resp code OKAY=00.
- One sub-module natural: `ysyx_25050147_store_lane` — combinational op/offset -> `wdata`, `wstrb`, misalign flag.

## Test plan
- sb, addr 0x8000_0003, data 0x0000_00AB, ready/bvalid immediate -> `awaddr` 0x8000_0000, `wdata` 0xAB00_0000, `wstrb` 1000, `resp_valid` at T+3, `resp_err`=0.
- sh, addr 0x8000_0002, data 0x1234; `wready` held low 3 cycles after `awready` -> AW drops after handshake, W persists, `wdata` 0x1234_0000, `wstrb` 1100, one response.
- sw, addr 0x8000_0004, data 0xDEAD_BEEF, `bresp`=10 -> `wstrb` 1111, `resp_err`=1.
- sw, addr 0x8000_0001 with macro defined -> no `awvalid`/`wvalid`, `resp_valid`&`resp_err` at T+1; without macro -> `wstrb` 1110, `wdata` 0xADBE_EF00.
- op 011 -> error response at T+1, no bus activity.
- `rst_n` low while in WAIT_B -> state IDLE, all outputs 0, subsequent `bvalid` produces no `resp_valid`.
